// File: rtl/r4_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one recoder and one adder row reused for WIDTH/2 cycles.
// start/done handshake; the product is held until the next completion.
module r4_booth_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned ACC_W = WIDTH + 2;
    localparam int unsigned MQ_W  = WIDTH + 1;
    localparam int unsigned SH_W  = ACC_W + MQ_W;
    localparam int unsigned CNT_W = $clog2(WIDTH / 2) + 1;
    localparam int unsigned LAST  = WIDTH / 2 - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [MQ_W-1:0]    mq;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [ACC_W-1:0]        mc_ext;
    logic [ACC_W-1:0]        pp;
    logic [ACC_W-1:0]        sum;
    logic signed [SH_W-1:0]  shifted;

    // Booth digit select, partial-product add and the 2-bit arithmetic shift of {acc, mq}
    always_comb begin
        mc_ext = {{2{mcand[WIDTH-1]}}, mcand};
        pp     = '0;
        case (mq[2:0])
            3'b001, 3'b010: pp = mc_ext;
            3'b011:         pp = ACC_W'(mc_ext << 1);
            3'b100:         pp = ACC_W'(-(mc_ext << 1));
            3'b101, 3'b110: pp = ACC_W'(-mc_ext);
            default:        pp = '0;
        endcase
        sum     = acc + pp;
        shifted = $signed({sum, mq}) >>> 2;
    end

    // Control FSM and datapath registers; busy/done are registered state decodes
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            mcand <= '0;
            mq    <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        mq    <= {b, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= shifted[SH_W-1:MQ_W];
                    mq  <= shifted[MQ_W-1:0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(LAST)) begin
                        // product sits in {acc, mq[WIDTH:1]} after the final shift
                        p     <= shifted[2*WIDTH:1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
